// File: rtl/drac_pkg.sv
// Shared front-end types: the decode->rename instruction record, queue sizing,
// and the state type of the instruction-read controller.
package drac_pkg;

  localparam int NUM_SCALAR_INSTR              = 2;
  localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 8;
  localparam int IQ_CNT_W = $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        regfile_we;
    logic        stall_csr_fence;
  } id_ir_stage_t;

  typedef enum logic {
    IR_RUN,
    IR_SER_WAIT
  } ir_read_state_t;

  // Writes to x0 are discarded, so they never need a physical register.
  function automatic logic writes_reg(id_ir_stage_t e);
    return e.regfile_we && (e.rd != 5'd0);
  endfunction

endpackage

// File: rtl/ir_read_ctrl_if.sv
// Queue-side and rename-side signals of the instruction-read controller.
interface ir_read_ctrl_if
  import drac_pkg::*;
();
  logic                                     flush_i;
  logic                                     stall_i;
  id_ir_stage_t [NUM_SCALAR_INSTR-1:0]      iq_instr_i;
  logic [IQ_CNT_W-1:0]                      iq_count_i;
  logic [1:0]                               free_regs_i;
  logic                                     ser_done_i;
  logic [NUM_SCALAR_INSTR-1:0]              read_head_o;
  id_ir_stage_t [NUM_SCALAR_INSTR-1:0]      instr_o;
  logic [NUM_SCALAR_INSTR-1:0]              valid_o;
  logic [31:0]                              issued_cnt_o;

  modport master (
    input  flush_i, stall_i, iq_instr_i, iq_count_i, free_regs_i, ser_done_i,
    output read_head_o, instr_o, valid_o, issued_cnt_o
  );

  modport slave (
    output flush_i, stall_i, iq_instr_i, iq_count_i, free_regs_i, ser_done_i,
    input  read_head_o, instr_o, valid_o, issued_cnt_o
  );
endinterface

// File: rtl/ir_grant_logic.sv
// In-order dual-issue grant: slot 1 only rides along with slot 0 when neither
// serializes and the free-register budget covers both.
module ir_grant_logic
  import drac_pkg::*;
(
  input  logic                                en_i,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  id_ir_stage_t [NUM_SCALAR_INSTR-1:0] iq_instr_i,
  input  logic [IQ_CNT_W-1:0]                 iq_count_i,
  input  logic [1:0]                          free_regs_i,
  output logic [NUM_SCALAR_INSTR-1:0]         grant_o
);

  logic       we0, we1;
  logic [1:0] need_both;

  assign we0       = writes_reg(iq_instr_i[0]);
  assign we1       = writes_reg(iq_instr_i[1]);
  assign need_both = {1'b0, we0} + {1'b0, we1};

  always_comb begin
    grant_o    = '0;
    grant_o[0] = en_i && !flush_i && !stall_i
              && (iq_count_i != '0)
              && (!we0 || (free_regs_i != 2'd0));
    grant_o[1] = grant_o[0]
              && (iq_count_i >= IQ_CNT_W'(2))
              && !iq_instr_i[0].stall_csr_fence
              && !iq_instr_i[1].stall_csr_fence
              && (need_both <= free_regs_i);
  end

endmodule

// File: rtl/ir_read_ctrl.sv
// Reads up to two entries per cycle from the instruction queue into the rename
// register, and holds issue after a CSR/fence until it commits.
module ir_read_ctrl
  import drac_pkg::*;
(
  input  logic           clk_i,
  input  logic           rstn_i,
  ir_read_ctrl_if.master bus
);

  ir_read_state_t                      state;
  logic [NUM_SCALAR_INSTR-1:0]         grant;
  logic [NUM_SCALAR_INSTR-1:0]         valid_q;
  id_ir_stage_t [NUM_SCALAR_INSTR-1:0] instr_q;
  logic [31:0]                         cnt_q;
  logic [31:0]                         issued_now;

  ir_grant_logic u_grant (
    .en_i        (rstn_i && (state == IR_RUN)),
    .flush_i     (bus.flush_i),
    .stall_i     (bus.stall_i),
    .iq_instr_i  (bus.iq_instr_i),
    .iq_count_i  (bus.iq_count_i),
    .free_regs_i (bus.free_regs_i),
    .grant_o     (grant)
  );

  always_comb begin
    issued_now = '0;
    for (int i = 0; i < NUM_SCALAR_INSTR; i++)
      issued_now = issued_now + 32'(grant[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= IR_RUN;
      valid_q <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else if (bus.flush_i) begin
      state   <= IR_RUN;
      valid_q <= '0;
    end else begin
      if (!bus.stall_i) begin
        valid_q <= grant;
        for (int i = 0; i < NUM_SCALAR_INSTR; i++)
          instr_q[i] <= grant[i] ? bus.iq_instr_i[i] : '0;
      end
      // The FSM advances under stall so a ser_done pulse is never lost.
      case (state)
        IR_RUN:      if (grant[0] && bus.iq_instr_i[0].stall_csr_fence) state <= IR_SER_WAIT;
        IR_SER_WAIT: if (bus.ser_done_i) state <= IR_RUN;
        default:     state <= IR_RUN;
      endcase
      cnt_q <= cnt_q + issued_now;
    end
  end

  assign bus.read_head_o  = grant;
  assign bus.valid_o      = valid_q;
  assign bus.instr_o      = instr_q;
  assign bus.issued_cnt_o = cnt_q;

endmodule

// File: tb/tb_ir_read_ctrl.sv
// Randomized bench for ir_read_ctrl against a rule-level model, plus directed
// scenarios with hand-computed expectations.
module tb_ir_read_ctrl;
  import drac_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ir_read_ctrl_if bus ();

  ir_read_ctrl dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.master)
  );

  int vectors = 0;
  int errors  = 0;

  // model state
  bit           m_ser;
  logic [1:0]   m_valid;
  id_ir_stage_t m_instr [2];
  logic [31:0]  m_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int need(input id_ir_stage_t e);
    return (e.regfile_we && e.rd != 0) ? 1 : 0;
  endfunction

  // Grants from the rules: in order, budgeted by free registers, nothing while
  // waiting on a serializing instruction, nothing under flush/stall/reset.
  function automatic logic [1:0] model_grant(input logic r, input logic fl, input logic st,
                                             input int cnt, input int fr,
                                             input id_ir_stage_t i0, input id_ir_stage_t i1);
    if (!r || m_ser || fl || st || cnt < 1) return 2'b00;
    if (need(i0) > fr) return 2'b00;
    if (cnt >= 2 && !i0.stall_csr_fence && !i1.stall_csr_fence && need(i0) + need(i1) <= fr)
      return 2'b11;
    return 2'b01;
  endfunction

  function automatic id_ir_stage_t mk(input bit we, input logic [4:0] rd, input bit ser);
    id_ir_stage_t e;
    e.pc = $urandom; e.instr = $urandom; e.rd = rd; e.regfile_we = we; e.stall_csr_fence = ser;
    return e;
  endfunction

  function automatic id_ir_stage_t rnd_instr();
    logic [4:0] rd;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return mk(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 5) == 0));
  endfunction

  task automatic cyc(input logic r, input logic fl, input logic st, input int cnt, input int fr,
                     input logic sd, input id_ir_stage_t i0, input id_ir_stage_t i1);
    logic [1:0] g;
    @(negedge clk);
    rstn = r;
    bus.flush_i = fl; bus.stall_i = st; bus.iq_count_i = IQ_CNT_W'(cnt);
    bus.free_regs_i = 2'(fr); bus.ser_done_i = sd;
    bus.iq_instr_i[0] = i0; bus.iq_instr_i[1] = i1;
    #1;
    g = model_grant(r, fl, st, cnt, fr, i0, i1);
    chk("read_head", 128'(bus.read_head_o), 128'(g));
    if (!r) begin
      m_ser = 0; m_valid = 0; m_instr[0] = '0; m_instr[1] = '0; m_cnt = 0;
    end else if (fl) begin
      m_ser = 0; m_valid = 0;
    end else begin
      if (!st) begin
        m_valid = g;
        m_instr[0] = g[0] ? i0 : '0;
        m_instr[1] = g[1] ? i1 : '0;
      end
      if (m_ser && sd) m_ser = 0;
      else if (g[0] && i0.stall_csr_fence) m_ser = 1;
      m_cnt = m_cnt + 32'(g[0]) + 32'(g[1]);
    end
    @(posedge clk);
    #1;
    chk("valid", 128'(bus.valid_o), 128'(m_valid));
    chk("issued_cnt", 128'(bus.issued_cnt_o), 128'(m_cnt));
    for (int i = 0; i < 2; i++)
      if (m_valid[i]) chk($sformatf("instr%0d", i), 128'(bus.instr_o[i]), 128'(m_instr[i]));
    if (!r) chk("instr_rst", 128'(bus.instr_o), 128'(0));
  endtask

  id_ir_stage_t w0, w1, f0, nw;

  initial begin
    rstn = 1'b0;
    bus.flush_i = 0; bus.stall_i = 0; bus.iq_count_i = '0; bus.free_regs_i = '0;
    bus.ser_done_i = 0; bus.iq_instr_i = '0;
    m_ser = 0; m_valid = 0; m_cnt = 0; m_instr[0] = '0; m_instr[1] = '0;

    w0 = mk(1, 5'd3, 0); w1 = mk(1, 5'd7, 0); f0 = mk(0, 5'd0, 1); nw = mk(0, 5'd9, 0);

    // reset state
    cyc(0, 1, 1, 5, 2, 0, w0, w1);
    cyc(0, 0, 0, 5, 2, 0, w0, w1);
    chk("rst_valid_lit", 128'(bus.valid_o), 128'(2'b00));
    chk("rst_cnt_lit", 128'(bus.issued_cnt_o), 128'(0));

    // full dual issue streaming
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0, 5, 2, 0, w0, w1);
      chk("stream_valid_lit", 128'(bus.valid_o), 128'(2'b11));
      chk("stream_cnt_lit", 128'(bus.issued_cnt_o), 128'(2 * k));
    end

    // single entry available, then register budget for only one
    cyc(1, 0, 0, 1, 2, 0, w0, w1);
    chk("cnt1_valid_lit", 128'(bus.valid_o), 128'(2'b01));
    cyc(1, 0, 0, 5, 1, 0, w0, w1);
    chk("free1_valid_lit", 128'(bus.valid_o), 128'(2'b01));
    chk("free1_cnt_lit", 128'(bus.issued_cnt_o), 128'(8));

    // x0 destination needs no free register
    cyc(1, 0, 0, 5, 0, 0, mk(1, 5'd0, 0), nw);
    chk("x0_valid_lit", 128'(bus.valid_o), 128'(2'b11));
    chk("x0_cnt_lit", 128'(bus.issued_cnt_o), 128'(10));

    // fence in slot 0 issues alone, then waits for ser_done
    cyc(1, 0, 0, 5, 2, 0, f0, w1);
    chk("fence_valid_lit", 128'(bus.valid_o), 128'(2'b01));
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 5, 2, 0, w0, w1);
    chk("serwait_valid_lit", 128'(bus.valid_o), 128'(2'b00));
    cyc(1, 0, 0, 5, 2, 1, w0, w1);
    chk("serdone_valid_lit", 128'(bus.valid_o), 128'(2'b00));
    chk("serdone_cnt_lit", 128'(bus.issued_cnt_o), 128'(11));
    cyc(1, 0, 0, 5, 2, 0, w0, w1);
    chk("resume_valid_lit", 128'(bus.valid_o), 128'(2'b11));
    chk("resume_cnt_lit", 128'(bus.issued_cnt_o), 128'(13));

    // fence in slot 1 is held back to next cycle
    cyc(1, 0, 0, 5, 2, 0, w0, f0);
    chk("fence1_valid_lit", 128'(bus.valid_o), 128'(2'b01));

    // stall holds output register
    cyc(1, 0, 0, 5, 2, 0, w0, w1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 5, 2, 0, mk(1, 5'd4, 0), mk(1, 5'd5, 0));
    chk("stall_valid_lit", 128'(bus.valid_o), 128'(2'b11));
    chk("stall_instr_lit", 128'(bus.instr_o[1]), 128'(w1));
    chk("stall_cnt_lit", 128'(bus.issued_cnt_o), 128'(16));

    // flush with stall in SER_WAIT
    cyc(1, 0, 0, 5, 2, 0, f0, w1);
    cyc(1, 1, 1, 5, 2, 0, w0, w1);
    chk("flush_valid_lit", 128'(bus.valid_o), 128'(2'b00));
    chk("flush_cnt_lit", 128'(bus.issued_cnt_o), 128'(17));
    cyc(1, 0, 0, 5, 2, 0, w0, w1);
    chk("postflush_valid_lit", 128'(bus.valid_o), 128'(2'b11));

    // one-edge reset mid-stream
    cyc(0, 0, 0, 5, 2, 0, w0, w1);
    chk("midrst_cnt_lit", 128'(bus.issued_cnt_o), 128'(0));
    cyc(1, 0, 0, 5, 2, 0, w0, w1);
    chk("postrst_cnt_lit", 128'(bus.issued_cnt_o), 128'(2));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 59) != 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 4) == 0),
          $urandom_range(0, INSTRUCTION_QUEUE_NUM_ENTRIES),
          $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0),
          rnd_instr(), rnd_instr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ir_read_ctrl.md
IR_READ_CTRL -- requirements
Module: ir_read_ctrl

Interface
REQ-001 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 Port rstn_i  input  1  reset, synchronous, active-low.
REQ-003 Port flush_i  input  1  pipeline flush from the control unit.
REQ-004 Port stall_i  input  1  rename stage cannot accept a new pair this cycle.
REQ-005 Port iq_instr_i  input  NUM_SCALAR_INSTR x id_ir_stage_t  queue entries at head (slot 0) and head+1 (slot 1).
REQ-006 Port iq_count_i  input  $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES)+1  valid entries currently held by the instruction queue.
REQ-007 Port free_regs_i  input  2  free physical registers available this cycle, saturated at 2.
REQ-008 Port ser_done_i  input  1  single-cycle pulse: serializing instruction has committed.
REQ-009 Port read_head_o  output  NUM_SCALAR_INSTR x 1  per-slot read strobe to the instruction queue.
REQ-010 Port instr_o  output  NUM_SCALAR_INSTR x id_ir_stage_t  registered instruction pair to rename.
REQ-011 Port valid_o  output  NUM_SCALAR_INSTR x 1  registered per-slot valid.
REQ-012 Port issued_cnt_o  output  32  count of instructions issued since reset.

Function
REQ-013 Grant for slot 0 (g0) SHALL be: state RUN, ~flush_i, ~stall_i, iq_count_i>=1, and free_regs_i>=1 if slot 0 writes a register.
REQ-014 Grant for slot 1 (g1) SHALL require g0, iq_count_i>=2, slot 0 not serializing, slot 1 not serializing, and enough free registers for both slots' register writes combined.
REQ-015 Grants SHALL be in order: g1 never asserted without g0.
REQ-016 read_head_o[i] SHALL equal gi, combinationally, in the same cycle.
REQ-017 When ~stall_i and ~flush_i, instr_o/valid_o SHALL load the granted entries next cycle; ungranted slots load valid 0; latency one cycle.
REQ-018 When stall_i and ~flush_i, instr_o/valid_o SHALL hold their values and no read strobe SHALL assert.
REQ-019 flush_i SHALL clear valid_o next cycle, force read_head_o to 0 that cycle, and return the FSM to RUN; flush beats stall.
REQ-020 FSM states: RUN and SER_WAIT.
REQ-021 RUN -> SER_WAIT when g0 and slot 0 carries the CSR/fence-stall flag; that instruction issues alone.
REQ-022 SER_WAIT: no grants; -> RUN on the cycle after ser_done_i; ser_done_i in RUN is ignored.
REQ-023 A serializing instruction in slot 1 SHALL NOT be granted; it issues next from slot 0.
REQ-024 issued_cnt_o SHALL add g0+g1 each cycle, wrap modulo 2^32, and not clear on flush.
REQ-025 Register-write demand per slot SHALL be its decoded regfile-write-enable field, excluding destination x0.

Reset
REQ-026 On a clock edge with rstn_i low: valid_o=0, instr_o=0, FSM=RUN, issued_cnt_o=0; read_head_o=0 while rstn_i low.
REQ-027 Reset SHALL take priority over flush_i and stall_i, including mid-SER_WAIT.

Structure
REQ-028 Shared package drac_pkg SHALL hold id_ir_stage_t, NUM_SCALAR_INSTR, INSTRUCTION_QUEUE_NUM_ENTRIES, and a new ir_read_state_t enum.
REQ-029 One sub-module, ir_grant_logic (pure combinational grant computation), SHALL be instantiated; the FSM, output register, and counter stay in ir_read_ctrl.

Verification
REQ-030 iq_count_i=5, free_regs_i=2, both slots write registers, no stall -> read_head_o=11 each cycle; valid_o=11 one cycle later; issued_cnt_o +2 per cycle.
REQ-031 iq_count_i=1 -> read_head_o=10; next cycle valid_o=10. Then free_regs_i=1 with both slots writing -> read_head_o=10.
REQ-032 Slot 0 is a fence -> read_head_o=10; FSM=SER_WAIT; read_head_o=00 until ser_done_i pulses; grants resume the cycle after the pulse.
REQ-033 stall_i high 3 cycles with valid_o=11 -> instr_o/valid_o unchanged; read_head_o=00; issued_cnt_o constant.
REQ-034 flush_i together with stall_i while in SER_WAIT -> read_head_o=00; next cycle valid_o=00 and FSM=RUN; issued_cnt_o unchanged.
REQ-035 rstn_i low one edge during streaming -> valid_o=00 and issued_cnt_o=0 after the edge; normal grants resume the first cycle rstn_i is high.
